// File: rtl/drive_pkg.sv
// Shared driving-FSM encodings: car states, route command codes and one-hot motion strobes.
package drive_pkg;

    localparam logic [1:0] S_WAIT = 2'b00;
    localparam logic [1:0] S_FWD  = 2'b01;
    localparam logic [1:0] S_TURN = 2'b10;
    localparam logic [1:0] S_COOL = 2'b11;

    localparam logic [1:0] CMD_STRAIGHT = 2'b00;
    localparam logic [1:0] CMD_LEFT     = 2'b01;
    localparam logic [1:0] CMD_RIGHT    = 2'b10;
    localparam logic [1:0] CMD_UTURN    = 2'b11;

    // motion vector order is {straight, back, left, right}
    localparam logic [3:0] MOT_NONE     = 4'b0000;
    localparam logic [3:0] MOT_STRAIGHT = 4'b1000;
    localparam logic [3:0] MOT_BACK     = 4'b0100;
    localparam logic [3:0] MOT_LEFT     = 4'b0010;
    localparam logic [3:0] MOT_RIGHT    = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ISSUE,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } route_state_t;

    function automatic logic [3:0] cmd_to_motion(input logic [1:0] cmd);
        logic [3:0] mot;
        mot = MOT_NONE;
        case (cmd)
            CMD_STRAIGHT: mot = MOT_STRAIGHT;
            CMD_LEFT:     mot = MOT_LEFT;
            CMD_RIGHT:    mot = MOT_RIGHT;
            CMD_UTURN:    mot = MOT_BACK;
            default:      mot = MOT_NONE;
        endcase
        return mot;
    endfunction

    // left and right together cancel unless a higher-priority button is pressed
    function automatic logic [3:0] manual_motion(input logic s, input logic b,
                                                 input logic l, input logic r);
        logic [3:0] mot;
        mot = MOT_NONE;
        if (s)           mot = MOT_STRAIGHT;
        else if (b)      mot = MOT_BACK;
        else if (l && r) mot = MOT_NONE;
        else if (l)      mot = MOT_LEFT;
        else if (r)      mot = MOT_RIGHT;
        return mot;
    endfunction

endpackage

// File: rtl/route_mem.sv
// Route storage: DEPTH x 2-bit command register file, synchronous write, asynchronous read.
module route_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_20ms,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk_20ms) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/route_sequencer.sv
// Route scheduler: replays stored turn commands at each crossroad stop, or arbitrates
// the push-buttons in manual mode. All outputs are registered on clk_20ms.
//
// state | meaning
// IDLE  | programming allowed, manual arbitration when mode=0
// ARM   | waiting for two consecutive S_WAIT samples
// ISSUE | driving command of cur_idx until the car leaves S_WAIT
// GAP   | one idle tick between re-issues
// DONE  | last entry accepted
// FAULT | command never accepted, outputs forced low until enable drops
module route_sequencer
    import drive_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int HOLD_TICKS = 10,
    parameter int MAX_RETRY  = 3
) (
    input  logic                     clk_20ms,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [1:0]               car_state,
    input  logic                     prog_we,
    input  logic [1:0]               prog_cmd,
    input  logic                     prog_clr,
    input  logic                     btn_straight,
    input  logic                     btn_back,
    input  logic                     btn_left,
    input  logic                     btn_right,
    output logic                     out_straight,
    output logic                     out_back,
    output logic                     out_left,
    output logic                     out_right,
    output logic [$clog2(DEPTH):0]   route_len,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic                     route_done,
    output logic                     fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_TICKS) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [AW:0]   LEN_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    route_state_t  state_q, state_d;
    logic          wait_q, wait_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [3:0]    mot_q, mot_d;
    logic          done_q, fault_q;
    logic          mem_we;
    logic [1:0]    cur_cmd;
    logic          last_entry;

    route_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_20ms (clk_20ms),
        .rst      (rst),
        .we       (mem_we),
        .waddr    (len_q[AW-1:0]),
        .wdata    (prog_cmd),
        .raddr    (idx_q),
        .rdata    (cur_cmd)
    );

    assign last_entry = ({1'b0, idx_q} == (len_q - LEN_ONE));

    always_ff @(posedge clk_20ms) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            hold_q  <= '0;
            retry_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            mot_q   <= MOT_NONE;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            retry_q <= retry_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mot_q   <= mot_d;
            done_q  <= (state_d == ST_DONE);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = 1'b0;
        hold_d  = hold_q;
        retry_d = retry_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mot_d   = MOT_NONE;
        mem_we  = 1'b0;

        // route edits: clear beats append when both arrive together
        if ((state_q == ST_IDLE || state_q == ST_DONE) && prog_clr) begin
            len_d = '0;
            idx_d = '0;
        end else if (state_q == ST_IDLE && prog_we && len_q != LEN_FULL) begin
            mem_we = 1'b1;
            len_d  = len_q + LEN_ONE;
        end

        if (enable && !mode && state_q != ST_FAULT)
            mot_d = manual_motion(btn_straight, btn_back, btn_left, btn_right);

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d   = '0;
                    retry_d = '0;
                    if (mode && len_q != '0 && !prog_clr) state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (!mode) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        wait_d = (car_state == S_WAIT);
                        if (car_state == S_WAIT && wait_q) begin
                            state_d = ST_ISSUE;
                            hold_d  = '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!mode) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else if (car_state != S_WAIT) begin
                        retry_d = '0;
                        if (last_entry) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = ST_ARM;
                        end
                    end else begin
                        mot_d = cmd_to_motion(cur_cmd);
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_GAP;
                            retry_d = retry_q + RW'(1);
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!mode) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_ISSUE;
                        hold_d  = '0;
                    end
                end
                ST_DONE: begin
                    if (prog_clr || !mode) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign {out_straight, out_back, out_left, out_right} = mot_q;
    assign route_len  = len_q;
    assign cur_idx    = idx_q;
    assign route_done = done_q;
    assign fault      = fault_q;

endmodule
